// File: rtl/addsub_block_accum_if.sv
// Handshake bundle between the add/sub result stream, the block accumulator
// and the block-total consumer.
interface addsub_block_accum_if #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 40,
  parameter int CNT_W     = 17
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [CNT_W-1:0]     out_count;
  logic                 out_ovf;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/addsub_block_accum.sv
// Sums BLOCK_LEN signed samples (or fewer on flush) and hands each block total,
// its sample count and a sticky overflow flag to the consumer.
module addsub_block_accum #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 40,
  parameter int BLOCK_LEN = 16,
  parameter int CNT_W     = 17
) (
  input  logic clk,
  input  logic rst,
  addsub_block_accum_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [CNT_W-1:0] BLK = CNT_W'(BLOCK_LEN);

  state_t               state, state_nx;
  logic [ACC_WIDTH-1:0] acc, acc_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic                 ovf, ovf_nx;
  logic                 ov_q, ov_nx;
  logic [ACC_WIDTH-1:0] os_q, os_nx;
  logic [CNT_W-1:0]     oc_q, oc_nx;
  logic                 oo_q, oo_nx;

  logic                 accept, close, add_ovf;
  logic [ACC_WIDTH-1:0] sext, sum;

  assign bus.in_ready  = rst && (state != DONE);
  assign bus.out_valid = ov_q;
  assign bus.out_sum   = os_q;
  assign bus.out_count = oc_q;
  assign bus.out_ovf   = oo_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign sext   = {{(ACC_WIDTH-WIDTH){bus.in_data[WIDTH-1]}}, bus.in_data};
  assign sum    = acc + sext;
  // Signed overflow: like-signed operands producing a result of the other sign.
  assign add_ovf = (acc[ACC_WIDTH-1] == sext[ACC_WIDTH-1]) &&
                   (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      ov_q  <= 1'b0;
      os_q  <= '0;
      oc_q  <= '0;
      oo_q  <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      ovf   <= ovf_nx;
      ov_q  <= ov_nx;
      os_q  <= os_nx;
      oc_q  <= oc_nx;
      oo_q  <= oo_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    ovf_nx   = ovf;
    ov_nx    = ov_q;
    os_nx    = os_q;
    oc_nx    = oc_q;
    oo_nx    = oo_q;
    close    = 1'b0;
    case (state)
      IDLE: begin
        // A flush without a sample is dropped so empty blocks never appear.
        if (accept) begin
          acc_nx   = sext;
          cnt_nx   = CNT_W'(1);
          ovf_nx   = 1'b0;
          state_nx = ACCUM;
          close    = bus.flush;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_nx = sum;
          cnt_nx = cnt + CNT_W'(1);
          ovf_nx = ovf | add_ovf;
        end
        close = bus.flush || (accept && (cnt_nx == BLK));
      end
      DONE: begin
        if (ov_q && bus.out_ready) begin
          ov_nx    = 1'b0;
          acc_nx   = '0;
          cnt_nx   = '0;
          ovf_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Result registers capture the post-update totals of the closing cycle.
    if (close) begin
      ov_nx    = 1'b1;
      os_nx    = acc_nx;
      oc_nx    = cnt_nx;
      oo_nx    = ovf_nx;
      state_nx = DONE;
    end
  end
endmodule
